lsu_master: RTL and testbench

- Load/store initiator between the core's execute stage and the word-addressed data memory.
- Accepts one load or store request per handshake and drives a valid/ready word-wide memory port with byte strobes.
- Aligns store data into byte lanes; extracts, sign-extends or zero-extends load data, then returns a single response to the core.
- Owns the requester side of the memory access that the data memory currently decodes from lb/lh/lw/lbu/lhu/sb/sh/sw flags.

---
 rtl/lsu_master.sv | 145 ++++++++++++++
 tb/tb_lsu_master.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_master.sv
// Load/store initiator: one core request in, one word-wide memory access out, one response back.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_master #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t      state;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;

    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        funct3_ok;
    logic        range_fault;
    logic        align_fault;
    logic        req_fault;
    logic [1:0]  lane_off;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [31:0] ld_shift;
    logic [31:0] ld_data;

    assign req_ready = (state == IDLE);

    // Request decode: size, fault detection and store lane alignment.
    always_comb begin
        is_byte     = (req_funct3[1:0] == 2'b00);
        is_half     = (req_funct3[1:0] == 2'b01);
        is_word     = (req_funct3 == 3'b010);
        if (req_is_store)
            funct3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        else
            funct3_ok = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) && (req_funct3 != 3'b111);
        range_fault = (32'(req_addr[31:2]) >= MEM_WORDS);
`ifdef LSU_MISALIGN_TRAP_EN
        align_fault = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
`else
        align_fault = 1'b0;
`endif
        req_fault   = !funct3_ok || range_fault || align_fault;

        lane_off = 2'b00;
        st_strb  = 4'b1111;
        st_data  = req_wdata;
        if (is_byte) begin
            lane_off = req_addr[1:0];
            st_strb  = 4'b0001 << req_addr[1:0];
            st_data  = {4{req_wdata[7:0]}};
        end else if (is_half) begin
            lane_off = {req_addr[1], 1'b0};
            st_strb  = 4'b0011 << {req_addr[1], 1'b0};
            st_data  = {2{req_wdata[15:0]}};
        end
    end

    // Load extraction from the lane offset captured at accept time.
    always_comb begin
        ld_shift = mem_rdata >> {lane_q, 3'b000};
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {24'h0, ld_shift[7:0]};
            3'b101:  ld_data = {16'h0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    // Control FSM with registered memory-port and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            funct3_q   <= 3'b000;
            lane_q     <= 2'b00;
            mem_valid  <= 1'b0;
            mem_addr   <= 32'h0;
            mem_we     <= 1'b0;
            mem_wstrb  <= 4'b0000;
            mem_wdata  <= 32'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q <= req_funct3;
                        lane_q   <= lane_off;
                        if (req_fault) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            state     <= BUS;
                            mem_valid <= 1'b1;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_we    <= req_is_store;
                            mem_wstrb <= req_is_store ? st_strb : 4'b0000;
                            mem_wdata <= req_is_store ? st_data : 32'h0;
                        end
                    end
                end
                BUS: begin
                    if (mem_ready) begin
                        state      <= RESP;
                        mem_valid  <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_wstrb  <= 4'b0000;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_rdata <= mem_we ? 32'h0 : ld_data;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_master.sv
// Directed self-checking bench for lsu_master with a behavioural word memory.
module tb_lsu_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    int checks = 0;
    int passed = 0;

    logic [31:0] mem [0:1023];

    logic        saw_mem;
    logic        got_resp;
    logic [31:0] cap_addr;
    logic        cap_we;
    logic [3:0]  cap_wstrb;
    logic [31:0] cap_wdata;
    logic [31:0] cap_rdata;
    logic        cap_fault;
    int          cap_lat;

    lsu_master #(.MEM_WORDS(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_valid && mem_ready && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        saw_mem  = 1'b0;
        got_resp = 1'b0;
        cap_lat  = -1;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !got_resp; i++) begin
            if (mem_valid && !saw_mem) begin
                saw_mem = 1'b1; cap_addr = mem_addr; cap_we = mem_we;
                cap_wstrb = mem_wstrb; cap_wdata = mem_wdata;
            end
            if (resp_valid) begin
                got_resp = 1'b1; cap_rdata = resp_rdata; cap_fault = resp_fault; cap_lat = i;
            end else begin
                @(negedge clk);
            end
        end
        if (!got_resp) begin
            checks++;
            $display("[TB] FAIL resp_timeout addr=%h got no resp_valid, required one", a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) $display("[TB] FAIL rst_req_ready got=%b exp=1", req_ready); else passed++;
        checks++; if (mem_valid !== 1'b0 || mem_we !== 1'b0 || mem_wstrb !== 4'b0000) $display("[TB] FAIL rst_mem_ctl got=%b%b%b exp=0 0 0000", mem_valid, mem_we, mem_wstrb); else passed++;
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) $display("[TB] FAIL rst_mem_data got=%h/%h exp=0/0", mem_addr, mem_wdata); else passed++;
        checks++; if (resp_valid !== 1'b0 || resp_fault !== 1'b0 || resp_rdata !== 32'h0) $display("[TB] FAIL rst_resp got=%b %b %h exp=0 0 0", resp_valid, resp_fault, resp_rdata); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || mem_valid !== 1'b0) $display("[TB] FAIL post_rst got ready=%b valid=%b exp=1 0", req_ready, mem_valid); else passed++;
    endtask

    task automatic test_word();
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        checks++; if (cap_wstrb !== 4'b1111 || cap_we !== 1'b1) $display("[TB] FAIL sw_strb got=%b we=%b exp=1111 1", cap_wstrb, cap_we); else passed++;
        checks++; if (cap_addr !== 32'h10 || cap_wdata !== 32'hDEADBEEF) $display("[TB] FAIL sw_addr_data got=%h/%h exp=10/deadbeef", cap_addr, cap_wdata); else passed++;
        checks++; if (cap_lat !== 1 || cap_rdata !== 32'h0 || cap_fault !== 1'b0) $display("[TB] FAIL sw_resp got lat=%0d rdata=%h fault=%b exp=1 0 0", cap_lat, cap_rdata, cap_fault); else passed++;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) $display("[TB] FAIL sw_pulse got=%b exp=0", resp_valid); else passed++;
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (cap_we !== 1'b0 || cap_wstrb !== 4'b0000) $display("[TB] FAIL lw_ctl got we=%b strb=%b exp=0 0000", cap_we, cap_wstrb); else passed++;
        checks++; if (cap_rdata !== 32'hDEADBEEF || cap_fault !== 1'b0) $display("[TB] FAIL lw_data got=%h fault=%b exp=deadbeef 0", cap_rdata, cap_fault); else passed++;
    endtask

    task automatic test_byte();
        issue(1'b1, 3'b000, 32'h13, 32'h12345680);
        checks++; if (cap_wstrb !== 4'b1000 || cap_wdata !== 32'h80808080) $display("[TB] FAIL sb_lane got strb=%b data=%h exp=1000 80808080", cap_wstrb, cap_wdata); else passed++;
        checks++; if (cap_addr !== 32'h10) $display("[TB] FAIL sb_addr got=%h exp=10", cap_addr); else passed++;
        issue(1'b0, 3'b000, 32'h13, 32'h0);
        checks++; if (cap_rdata !== 32'hFFFFFF80) $display("[TB] FAIL lb_sext got=%h exp=ffffff80", cap_rdata); else passed++;
        issue(1'b0, 3'b100, 32'h13, 32'h0);
        checks++; if (cap_rdata !== 32'h00000080) $display("[TB] FAIL lbu_zext got=%h exp=00000080", cap_rdata); else passed++;
        issue(1'b0, 3'b000, 32'h11, 32'h0);
        checks++; if (cap_rdata !== 32'hFFFFFFBE) $display("[TB] FAIL lb_lane1 got=%h exp=ffffffbe", cap_rdata); else passed++;
    endtask

    task automatic test_half();
        issue(1'b1, 3'b001, 32'h22, 32'hAAAA8001);
        checks++; if (cap_wstrb !== 4'b1100 || cap_wdata !== 32'h80018001) $display("[TB] FAIL sh_lane got strb=%b data=%h exp=1100 80018001", cap_wstrb, cap_wdata); else passed++;
        checks++; if (cap_addr !== 32'h20) $display("[TB] FAIL sh_addr got=%h exp=20", cap_addr); else passed++;
        issue(1'b0, 3'b001, 32'h22, 32'h0);
        checks++; if (cap_rdata !== 32'hFFFF8001) $display("[TB] FAIL lh_sext got=%h exp=ffff8001", cap_rdata); else passed++;
        issue(1'b0, 3'b101, 32'h22, 32'h0);
        checks++; if (cap_rdata !== 32'h00008001) $display("[TB] FAIL lhu_zext got=%h exp=00008001", cap_rdata); else passed++;
    endtask

    task automatic test_fault();
        issue(1'b0, 3'b010, 32'h1000, 32'h0);
        checks++; if (cap_fault !== 1'b1 || saw_mem !== 1'b0) $display("[TB] FAIL range_fault got fault=%b mem=%b exp=1 0", cap_fault, saw_mem); else passed++;
        checks++; if (cap_lat !== 0 || cap_rdata !== 32'h0) $display("[TB] FAIL range_resp got lat=%0d rdata=%h exp=0 0", cap_lat, cap_rdata); else passed++;
        issue(1'b0, 3'b010, 32'hFFC, 32'h0);
        checks++; if (cap_fault !== 1'b0 || saw_mem !== 1'b1 || cap_addr !== 32'hFFC) $display("[TB] FAIL last_word got fault=%b mem=%b addr=%h exp=0 1 ffc", cap_fault, saw_mem, cap_addr); else passed++;
        issue(1'b0, 3'b011, 32'h10, 32'h0);
        checks++; if (cap_fault !== 1'b1 || saw_mem !== 1'b0) $display("[TB] FAIL bad_load_f3 got fault=%b mem=%b exp=1 0", cap_fault, saw_mem); else passed++;
        issue(1'b1, 3'b100, 32'h10, 32'h0);
        checks++; if (cap_fault !== 1'b1 || saw_mem !== 1'b0) $display("[TB] FAIL bad_store_f3 got fault=%b mem=%b exp=1 0", cap_fault, saw_mem); else passed++;
        @(negedge clk);
        checks++; if (resp_fault !== 1'b1 || resp_valid !== 1'b0) $display("[TB] FAIL fault_hold got fault=%b valid=%b exp=1 0", resp_fault, resp_valid); else passed++;
    endtask

    task automatic test_misalign();
        issue(1'b1, 3'b010, 32'h0, 32'h0000C3F1);
        issue(1'b0, 3'b001, 32'h01, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (cap_fault !== 1'b1 || saw_mem !== 1'b0) $display("[TB] FAIL lh_misalign got fault=%b mem=%b exp=1 0", cap_fault, saw_mem); else passed++;
`else
        checks++; if (cap_fault !== 1'b0 || cap_rdata !== 32'hFFFFC3F1) $display("[TB] FAIL lh_misalign got fault=%b rdata=%h exp=0 ffffc3f1", cap_fault, cap_rdata); else passed++;
`endif
    endtask

    task automatic test_backpressure();
        logic [31:0] a0, d0;
        logic [3:0]  s0;
        logic        stable;
        mem_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'h11223344;
        @(negedge clk);
        req_valid = 1'b0;
        a0 = mem_addr; d0 = mem_wdata; s0 = mem_wstrb; stable = 1'b1;
        checks++; if (a0 !== 32'h30 || d0 !== 32'h11223344 || s0 !== 4'b1111) $display("[TB] FAIL bp_first got %h %h %b exp 30 11223344 1111", a0, d0, s0); else passed++;
        for (int i = 0; i < 5; i++) begin
            if (mem_valid !== 1'b1 || mem_addr !== a0 || mem_wdata !== d0 || mem_wstrb !== s0 ||
                mem_we !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0) stable = 1'b0;
            @(negedge clk);
        end
        checks++; if (stable !== 1'b1) $display("[TB] FAIL bp_stable got=%b exp=1", stable); else passed++;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || mem_valid !== 1'b0) $display("[TB] FAIL bp_resp got valid=%b mem=%b exp=1 0", resp_valid, mem_valid); else passed++;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("[TB] FAIL bp_pulse got valid=%b ready=%b exp=0 1", resp_valid, req_ready); else passed++;
        issue(1'b0, 3'b010, 32'h30, 32'h0);
        checks++; if (cap_rdata !== 32'h11223344) $display("[TB] FAIL bp_readback got=%h exp=11223344", cap_rdata); else passed++;
    endtask

    task automatic test_reset_mid_bus();
        logic any_resp;
        mem_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (mem_valid !== 1'b1) $display("[TB] FAIL mid_bus_pre got=%b exp=1", mem_valid); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_valid !== 1'b0 || req_ready !== 1'b1) $display("[TB] FAIL mid_bus_async got valid=%b ready=%b exp=0 1", mem_valid, req_ready); else passed++;
        mem_ready = 1'b1;
        any_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) any_resp = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) any_resp = 1'b1;
        end
        checks++; if (any_resp !== 1'b0) $display("[TB] FAIL mid_bus_noresp got=%b exp=0", any_resp); else passed++;
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (cap_rdata !== 32'h80ADBEEF || cap_fault !== 1'b0) $display("[TB] FAIL post_rst_req got=%h fault=%b exp=80adbeef 0", cap_rdata, cap_fault); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_fault();
        test_misalign();
        test_backpressure();
        test_reset_mid_bus();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
